position_tracker: RTL and testbench

// - Downstream of the movement stage: consumes per-step delta_x/delta_y/sign_x/sign_y strobes, keeps ship position.
// - Wraps at screen edges (asteroids toroidal field); steps arriving while busy are accumulated, not lost.
// - On each position change, runs an erase-old / draw-new req/ack handshake with the sprite plotter.

---
 rtl/position_tracker_pkg.sv | 33 +++
 rtl/position_tracker_if.sv | 29 ++
 rtl/position_tracker_axis_wrap_add.sv | 30 +++
 rtl/position_tracker.sv | 152 +++++++++++++++
 tb/tb_position_tracker.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/position_tracker_pkg.sv
// Shared constants, state encoding and the pending-step saturation helper
// for the ship position tracker.
package position_tracker_pkg;

    localparam int POS_W_DEF    = 9;
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int INIT_X_DEF   = 80;
    localparam int INIT_Y_DEF   = 60;

    localparam int AXES     = 2;
    localparam int PEND_W   = 4;
    localparam int STEP_W   = 5;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_ERASE = 2'd2,
        S_DRAW  = 2'd3
    } state_t;

    // Clamp an accumulated step count to the +/-7 range the pending counter holds.
    function automatic logic signed [PEND_W-1:0] sat_pend(input logic signed [STEP_W-1:0] v);
        if (v > 5'sd7) begin
            return 4'sd7;
        end else if (v < -5'sd7) begin
            return -4'sd7;
        end else begin
            return v[PEND_W-1:0];
        end
    endfunction

endpackage

// File: rtl/position_tracker_if.sv
// Erase/draw request bus between the position tracker (master) and the
// sprite plotter (slave).
interface position_tracker_if
    import position_tracker_pkg::*;
#(
    parameter int POS_W = POS_W_DEF
);
    logic             draw_req;
    logic             draw_erase;
    logic [POS_W-1:0] draw_x;
    logic [POS_W-1:0] draw_y;
    logic             draw_ack;

    modport master (
        output draw_req,
        output draw_erase,
        output draw_x,
        output draw_y,
        input  draw_ack
    );

    modport slave (
        input  draw_req,
        input  draw_erase,
        input  draw_x,
        input  draw_y,
        output draw_ack
    );
endinterface

// File: rtl/position_tracker_axis_wrap_add.sv
// One axis of the toroidal field: adds a small signed offset to a coordinate
// and folds the result back into 0..SIZE-1.
module axis_wrap_add #(
    parameter int POS_W = 9,
    parameter int SIZE  = 160
) (
    input  logic [POS_W-1:0]  pos,
    input  logic signed [4:0] offset,
    output logic [POS_W-1:0]  wrapped
);
    localparam logic signed [POS_W:0] SIZE_S = (POS_W+1)'(SIZE);

    logic signed [POS_W:0] sum;
    logic signed [POS_W:0] adj;

    // Offset is at most +/-8 and SIZE >= 16, so a single fold is enough.
    always_comb begin
        sum = $signed({1'b0, pos}) + $signed({{(POS_W-4){offset[4]}}, offset});
        if (sum >= SIZE_S) begin
            adj = sum - SIZE_S;
        end else if (sum[POS_W]) begin
            adj = sum + SIZE_S;
        end else begin
            adj = sum;
        end
    end

    assign wrapped = POS_W'(adj);

endmodule

// File: rtl/position_tracker.sv
// Ship position tracker: accumulates step strobes, commits wrapped moves and
// runs the erase-old / draw-new handshake with the sprite plotter.
module position_tracker
    import position_tracker_pkg::*;
#(
    parameter int POS_W    = POS_W_DEF,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int INIT_X   = INIT_X_DEF,
    parameter int INIT_Y   = INIT_Y_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     move_clk,
    input  logic                     delta_x,
    input  logic                     delta_y,
    input  logic                     sign_x,
    input  logic                     sign_y,
    position_tracker_if.master       draw,
    output logic [POS_W-1:0]         pos_x,
    output logic [POS_W-1:0]         pos_y,
    output logic                     busy
);
    state_t                   state_reg, state_next;
    logic [POS_W-1:0]         pos_reg [AXES];
    logic [POS_W-1:0]         pos_next [AXES];
    logic [POS_W-1:0]         draw_pos_reg [AXES];
    logic [POS_W-1:0]         draw_pos_next [AXES];
    logic [POS_W-1:0]         wrapped [AXES];
    logic [POS_W-1:0]         init_pos [AXES];
    logic signed [PEND_W-1:0] pend_reg [AXES];
    logic signed [PEND_W-1:0] pend_next [AXES];
    logic signed [PEND_W-1:0] pend_sat [AXES];
    logic signed [STEP_W-1:0] eff [AXES];
    logic [AXES-1:0]          step_en;
    logic [AXES-1:0]          step_dec;
    logic                     req_reg, req_next;
    logic                     erase_reg, erase_next;
    logic                     busy_reg;
    logic                     ack;
    logic                     any_move;

    assign step_en  = {delta_y, delta_x} & {AXES{move_clk}};
    assign step_dec = {sign_y, sign_x};

    // Index 0 is x, index 1 is y; eff is the pending count plus this cycle's step.
    for (genvar gi = 0; gi < AXES; gi++) begin : g_axis
        localparam int SIZE = (gi == 0) ? SCREEN_W : SCREEN_H;
        localparam int INIT = (gi == 0) ? INIT_X : INIT_Y;

        logic signed [STEP_W-1:0] step;

        assign step = step_en[gi] ? (step_dec[gi] ? -5'sd1 : 5'sd1) : 5'sd0;
        assign eff[gi] = $signed({pend_reg[gi][PEND_W-1], pend_reg[gi]}) + step;
        assign pend_sat[gi] = sat_pend(eff[gi]);
        assign init_pos[gi] = POS_W'(INIT);

        axis_wrap_add #(
            .POS_W (POS_W),
            .SIZE  (SIZE)
        ) u_wrap (
            .pos     (pos_reg[gi]),
            .offset  (eff[gi]),
            .wrapped (wrapped[gi])
        );
    end

    assign any_move = (eff[0] != '0) || (eff[1] != '0);
    assign ack      = draw.draw_ack & req_reg;

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        erase_next = erase_reg;
        for (int i = 0; i < AXES; i++) begin
            pos_next[i]      = pos_reg[i];
            draw_pos_next[i] = draw_pos_reg[i];
            pend_next[i]     = pend_sat[i];
        end
        case (state_reg)
            S_INIT: begin
                req_next   = 1'b1;
                erase_next = 1'b0;
                for (int i = 0; i < AXES; i++) draw_pos_next[i] = init_pos[i];
                if (ack) begin
                    req_next   = 1'b0;
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                // Idle consumes the whole pending count in one combined move.
                for (int i = 0; i < AXES; i++) pend_next[i] = '0;
                if (any_move) begin
                    for (int i = 0; i < AXES; i++) begin
                        draw_pos_next[i] = pos_reg[i];
                        pos_next[i]      = wrapped[i];
                    end
                    erase_next = 1'b1;
                    req_next   = 1'b1;
                    state_next = S_ERASE;
                end
            end
            S_ERASE: begin
                if (ack) begin
                    for (int i = 0; i < AXES; i++) draw_pos_next[i] = pos_reg[i];
                    erase_next = 1'b0;
                    state_next = S_DRAW;
                end
            end
            S_DRAW: begin
                if (ack) begin
                    req_next   = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_reg <= S_INIT;
            req_reg   <= 1'b0;
            erase_reg <= 1'b0;
            busy_reg  <= 1'b1;
            for (int i = 0; i < AXES; i++) begin
                pos_reg[i]      <= init_pos[i];
                draw_pos_reg[i] <= '0;
                pend_reg[i]     <= '0;
            end
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            erase_reg <= erase_next;
            busy_reg  <= (state_next != S_IDLE);
            for (int i = 0; i < AXES; i++) begin
                pos_reg[i]      <= pos_next[i];
                draw_pos_reg[i] <= draw_pos_next[i];
                pend_reg[i]     <= pend_next[i];
            end
        end
    end

    assign draw.draw_req   = req_reg;
    assign draw.draw_erase = erase_reg;
    assign draw.draw_x     = draw_pos_reg[0];
    assign draw.draw_y     = draw_pos_reg[1];
    assign pos_x           = pos_reg[0];
    assign pos_y           = pos_reg[1];
    assign busy            = busy_reg;

endmodule

// File: tb/tb_position_tracker.sv
// Scoreboard bench for position_tracker: stimulus pushes expected plotter
// transactions, a monitor pops them on every accepted req/ack.
module tb_position_tracker;
    import position_tracker_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       move_clk;
    logic       delta_x;
    logic       delta_y;
    logic       sign_x;
    logic       sign_y;
    logic [8:0] pos_x;
    logic [8:0] pos_y;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int req_hi = 0;
    int exp_x = 80;
    int exp_y = 60;
    logic [18:0] sb[$];

    always #5 clk = ~clk;

    position_tracker_if #(.POS_W(9)) draw_bus ();

    position_tracker dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .move_clk (move_clk),
        .delta_x  (delta_x),
        .delta_y  (delta_y),
        .sign_x   (sign_x),
        .sign_y   (sign_y),
        .draw     (draw_bus),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .busy     (busy)
    );

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int wrap(input int p, input int d, input int size);
        int s;
        s = p + d;
        if (s >= size) s = s - size;
        else if (s < 0) s = s + size;
        return s;
    endfunction

    task automatic push(input logic e, input int x, input int y);
        sb.push_back({e, 9'(x), 9'(y)});
    endtask

    task automatic strobe(input logic dx, input logic dy, input logic sx, input logic sy);
        move_clk = 1'b1;
        delta_x  = dx;
        delta_y  = dy;
        sign_x   = sx;
        sign_y   = sy;
        tick();
        move_clk = 1'b0;
        delta_x  = 1'b0;
        delta_y  = 1'b0;
        sign_x   = 1'b0;
        sign_y   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: busy=%0d pending=%0d, expected idle within 200 cycles",
                     name, busy, sb.size());
        end
    endtask

    // Single move with ack held high: erase at the old position, draw at the new one.
    task automatic move(input string name, input logic dx, input logic dy,
                        input logic sx, input logic sy);
        int ddx, ddy;
        ddx = dx ? (sx ? -1 : 1) : 0;
        ddy = dy ? (sy ? -1 : 1) : 0;
        push(1'b1, exp_x, exp_y);
        exp_x = wrap(exp_x, ddx, 160);
        exp_y = wrap(exp_y, ddy, 120);
        push(1'b0, exp_x, exp_y);
        strobe(dx, dy, sx, sy);
        check({name, "_pos_x"}, pos_x, exp_x);
        check({name, "_pos_y"}, pos_y, exp_y);
        wait_idle(name);
    endtask

    // Monitor: every cycle with req and ack both high is one accepted transaction.
    initial begin
        logic [18:0] got;
        logic [18:0] want;
        forever begin
            @(negedge clk);
            if (!reset_n && draw_bus.draw_req) req_hi++;
            if (!reset_n && draw_bus.draw_req && draw_bus.draw_ack) begin
                got = {draw_bus.draw_erase, draw_bus.draw_x, draw_bus.draw_y};
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_xfer: got erase=%0d x=%0d y=%0d, expected none",
                             got[18], got[17:9], got[8:0]);
                end else begin
                    want = sb.pop_front();
                    if (got != want) begin
                        fails++;
                        $display("FAIL xfer: got erase=%0d x=%0d y=%0d, expected erase=%0d x=%0d y=%0d",
                                 got[18], got[17:9], got[8:0], want[18], want[17:9], want[8:0]);
                    end else begin
                        $display("[TB] xfer erase=%0d x=%0d y=%0d ok", got[18], got[17:9], got[8:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b1;
        move_clk = 1'b0;
        delta_x  = 1'b0;
        delta_y  = 1'b0;
        sign_x   = 1'b0;
        sign_y   = 1'b0;
        draw_bus.draw_ack = 1'b1;
        repeat (3) tick();

        check("reset_req", draw_bus.draw_req, 0);
        check("reset_erase", draw_bus.draw_erase, 0);
        check("reset_draw_x", draw_bus.draw_x, 0);
        check("reset_draw_y", draw_bus.draw_y, 0);
        check("reset_pos_x", pos_x, 80);
        check("reset_pos_y", pos_y, 60);
        check("reset_busy", busy, 1);

        req_hi = 0;
        push(1'b0, 80, 60);
        reset_n = 1'b0;
        wait_idle("init");
        check("init_req_cycles", req_hi, 1);
        check("init_busy", busy, 0);
        check("init_pos_x", pos_x, 80);
        check("init_pos_y", pos_y, 60);

        delta_x = 1'b1;
        delta_y = 1'b1;
        repeat (4) tick();
        delta_x = 1'b0;
        delta_y = 1'b0;
        check("ignore_busy", busy, 0);
        check("ignore_pos_x", pos_x, 80);
        check("ignore_pos_y", pos_y, 60);

        move("step_px", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 78; i++) move("walk_px", 1'b1, 1'b0, 1'b0, 1'b0);
        check("edge_pos_x", pos_x, 159);
        move("wrap_px", 1'b1, 1'b0, 1'b0, 1'b0);
        check("wrap_px_zero", pos_x, 0);
        move("wrap_nx", 1'b1, 1'b0, 1'b1, 1'b0);
        check("wrap_nx_max", pos_x, 159);
        for (int i = 0; i < 60; i++) move("walk_ny", 1'b0, 1'b1, 1'b0, 1'b1);
        check("edge_pos_y", pos_y, 0);
        move("wrap_ny", 1'b0, 1'b1, 1'b0, 1'b1);
        check("wrap_ny_max", pos_y, 119);
        move("diag", 1'b1, 1'b1, 1'b0, 1'b0);
        check("diag_pos_x", pos_x, 0);
        check("diag_pos_y", pos_y, 0);

        // Stalled plotter: three more +x steps pile up and commit as one +3 move.
        draw_bus.draw_ack = 1'b0;
        push(1'b1, exp_x, exp_y);
        exp_x = wrap(exp_x, 1, 160);
        push(1'b0, exp_x, exp_y);
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 3 || i == 8 || i == 13) strobe(1'b1, 1'b0, 1'b0, 1'b0);
            else tick();
        end
        check("acc_stall_req", draw_bus.draw_req, 1);
        check("acc_stall_pos_x", pos_x, 1);
        push(1'b1, exp_x, exp_y);
        exp_x = wrap(exp_x, 3, 160);
        push(1'b0, exp_x, exp_y);
        draw_bus.draw_ack = 1'b1;
        wait_idle("acc");
        check("acc_pos_x", pos_x, 4);

        // Ten -y steps while busy saturate the pending count at -7.
        draw_bus.draw_ack = 1'b0;
        push(1'b1, exp_x, exp_y);
        exp_y = wrap(exp_y, -1, 120);
        push(1'b0, exp_x, exp_y);
        strobe(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            strobe(1'b0, 1'b1, 1'b0, 1'b1);
            tick();
        end
        push(1'b1, exp_x, exp_y);
        exp_y = wrap(exp_y, -7, 120);
        push(1'b0, exp_x, exp_y);
        draw_bus.draw_ack = 1'b1;
        wait_idle("sat");
        check("sat_pos_y", pos_y, 112);

        // Reset while an erase request is outstanding.
        draw_bus.draw_ack = 1'b0;
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        check("abort_req_up", draw_bus.draw_req, 1);
        check("abort_erase_up", draw_bus.draw_erase, 1);
        reset_n = 1'b1;
        tick();
        check("abort_req", draw_bus.draw_req, 0);
        check("abort_pos_x", pos_x, 80);
        check("abort_pos_y", pos_y, 60);
        sb.delete();
        exp_x = 80;
        exp_y = 60;
        push(1'b0, 80, 60);
        reset_n = 1'b0;
        draw_bus.draw_ack = 1'b1;
        wait_idle("restart");
        check("restart_pos_x", pos_x, 80);
        move("post_reset", 1'b0, 1'b1, 1'b0, 1'b0);
        check("post_reset_pos_y", pos_y, 61);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
